// File: rtl/fxp_serial_mult.sv
// fxp_serial_mult
//   Sequential signed fixed-point multiplier. Two Q(para_int_bits).(para_frac_bits)
//   operands are accepted over an input handshake. The exact 2W-bit two's-complement
//   product is formed by a W-iteration unsigned shift-add loop on the operand
//   magnitudes, followed by one sign-fixup cycle. It is then offered over an output
//   handshake. Binary point of the product is at bit 2*para_frac_bits.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    block can accept operands (IDLE only)
//   a          in   W    signed multiplicand
//   b          in   W    signed multiplier
//   out_valid  out  1    product valid (DONE only)
//   out_ready  in   1    consumer accepts product
//   product    out  2W   signed exact product a*b, held until the next SIGN cycle
//   busy       out  1    high in CALC or SIGN
//   dbg_state  out  2    current FSM state (IDLE=0, CALC=1, SIGN=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid/ready never depend combinationally on the opposite side. in_ready,
// out_valid and busy are flops updated together with the state register.
module fxp_serial_mult #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [para_int_bits+para_frac_bits-1:0]       a,
  input  logic [para_int_bits+para_frac_bits-1:0]       b,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [2*(para_int_bits+para_frac_bits)-1:0]   product,
  output logic                                          busy,
  output logic [1:0]                                    dbg_state
);

  localparam int W  = para_int_bits + para_frac_bits;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    mcand_q;
  logic [W-1:0]    mplier_q;
  logic            neg_q;
  logic [2*W-1:0]  acc_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  product_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [W-1:0]    mcand_d;
  logic [W-1:0]    mplier_d;
  logic            neg_d;
  logic [2*W-1:0]  acc_d;
  logic [2*W-1:0]  product_d;
  logic            last_iter;

  always_comb begin
    mcand_d   = '0;
    mplier_d  = '0;
    neg_d     = 1'b0;
    acc_d     = acc_q;
    product_d = acc_q;
    last_iter = 1'b0;

    // Magnitudes as W-bit unsigned: -2^(W-1) negates to itself, which is
    // exactly 2^(W-1) when read as unsigned, so no extra bit is needed.
    mcand_d  = a[W-1] ? (~a + W'(1)) : a;
    mplier_d = b[W-1] ? (~b + W'(1)) : b;
    neg_d    = a[W-1] ^ b[W-1];

    if (mplier_q[0]) begin
      acc_d = acc_q + ({{W{1'b0}}, mcand_q} << cnt_q);
    end

    // Two's-complement negation of zero is zero, so a zero result stays zero
    // regardless of neg_q.
    product_d = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;

    last_iter = (cnt_q == CW'(W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            neg_q      <= neg_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          product_q   <= product_d;
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          // in_valid is deliberately ignored here; new operands wait for IDLE.
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fxp_serial_mult.sv
// Testbench for fxp_serial_mult (default parameters, W = 16).
// Stimulus is issued by driver tasks that push the expected product into
// exp_q at the acceptance edge. An independent monitor pops and compares on
// every output handshake. The reference is plain signed multiplication.
module tb_fxp_serial_mult;

  localparam int W   = 16;
  localparam int LAT = W + 1;
  localparam int N_RANDOM = 1500;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  logic             busy;
  logic [1:0]       dbg_state;

  int vectors;
  int miscompares;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  bit stim_done;

  fxp_serial_mult #(
    .para_int_bits (7),
    .para_frac_bits(9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xs;
    logic signed [2*W-1:0] ys;
    logic signed [2*W-1:0] p;
    xs = $signed(x);
    ys = $signed(y);
    p  = xs * ys;
    return p;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge when both are high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(product), 64'hDEAD_0000_0000_0000);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", 64'(product), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the acceptance edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2*W-1:0] expv);
    int waitc;
    waitc = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Accepts one pair with out_ready high and measures edges until out_valid.
  task automatic run_latency(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [2*W-1:0] expv);
    int  n;
    bit  ready_seen;
    bit  busy_dropped;
    out_ready = 1'b1;
    send(av, bv, expv);
    n = 0;
    ready_seen = 1'b0;
    busy_dropped = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) ready_seen = 1'b1;
      if (out_valid) break;
      if (!busy) busy_dropped = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'(LAT));
    check({name, "_in_ready_low"}, 64'(ready_seen), 64'd0);
    check({name, "_busy_high"}, 64'(busy_dropped), 64'd0);
    check({name, "_product"}, 64'(product), 64'(expv));
    drain();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      4:       return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2*W-1:0] held;
    int             n;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    vectors     = 0;
    miscompares = 0;
    stim_done   = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;

    // Reset values (async reset asserted before any clock edge).
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic fractional product with latency.
    run_latency("q_1p5x2p25", 16'h0300, 16'h0480, 32'h000D_8000);

    // Sign handling, both operand orders.
    out_ready = 1'b1;
    send(16'hFE00, 16'h0600, 32'hFFF4_0000);
    drain();
    send(16'h0600, 16'hFE00, 32'hFFF4_0000);
    drain();

    // Corner operands.
    send(16'h8000, 16'h8000, 32'h4000_0000);
    drain();
    send(16'h8000, 16'h7FFF, 32'hC000_8000);
    drain();
    send(16'h0000, 16'h8000, 32'h0000_0000);
    drain();
    send(16'hFFFF, 16'h0000, 32'h0000_0000);
    drain();

    // Backpressure: DONE holds while out_ready is low; in_valid is ignored.
    out_ready = 1'b0;
    send(16'h0123, 16'hF0F1, ref_mul(16'h0123, 16'hF0F1));
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_out_valid_rise", 64'(out_valid), 64'd1);
    held = product;
    check("bp_product", 64'(held), 64'(ref_mul(16'h0123, 16'hF0F1)));
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_product", 64'(product), 64'(held));
    end
    // Release with in_valid also high: only the output handshake completes.
    a = 16'h0200;
    b = 16'h0200;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);
    check("bp_product_kept", 64'(product), 64'(held));
    send(16'h0200, 16'h0200, 32'h0004_0000);
    drain();

    // Asynchronous reset in the middle of CALC.
    send(16'h7ABC, 16'h8123, ref_mul(16'h7ABC, 16'h8123));
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_product", 64'(product), 64'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_latency("post_rst", 16'hC3A5, 16'h1F2E, ref_mul(16'hC3A5, 16'h1F2E));

    // Randomized regression with input gaps and output stalls.
    fork
      begin
        for (int i = 0; i < N_RANDOM; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          ra = pick_operand();
          rb = pick_operand();
          send(ra, rb, ref_mul(ra, rb));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          if ($urandom_range(0, 15) == 0) out_ready = 1'b0;
          else out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
